// File: rtl/div_meter_pkg.sv
// rtl/div_meter_pkg.sv - shared types and constants for the period meter
// Purpose: FSM state encoding and default counter width used by div_period_meter.
// Contents: state_e (IDLE/ARM/MEASURE, 2-bit), CNT_W_DEF.
package div_meter_pkg;

   localparam int CNT_W_DEF = 28;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } state_e;

endpackage

// File: rtl/sig_sync_edge.sv
// rtl/sig_sync_edge.sv - input synchronizer with rise/fall detection
// Purpose: brings an asynchronous level into the clk domain and flags its edges.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   async_in   : asynchronous input level
//   level      : synchronized level (SYNC_STAGES cycles of latency)
//   rise, fall : one-cycle edge flags, aligned with level
module sig_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   if (SYNC_STAGES < 2) begin : g_bad_stages
      $error("sig_sync_edge: SYNC_STAGES must be at least 2");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/div_period_meter.sv
// rtl/div_period_meter.sv - period and high-time meter for a slow square wave
// Purpose: counts clk cycles between successive rising edges of i_sig and the
// high time within that period; reports both with a one-cycle valid strobe.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_sig      : measured waveform (asynchronous)
//   i_enable   : 1 = measure, 0 = return to IDLE
//   o_period   : last measured period in clk cycles
//   o_high     : high time of that period in clk cycles
//   o_valid    : one-cycle pulse when o_period/o_high update
//   o_timeout  : one-cycle pulse when no rising edge arrives within TIMEOUT
//   o_busy     : 1 while in ARM or MEASURE
module div_period_meter
   import div_meter_pkg::*;
#(
   parameter int          CNT_W       = CNT_W_DEF,
   parameter int unsigned TIMEOUT     = 100_000_000,
   parameter int          SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_sig,
   input  logic             i_enable,
   output logic [CNT_W-1:0] o_period,
   output logic [CNT_W-1:0] o_high,
   output logic             o_valid,
   output logic             o_timeout,
   output logic             o_busy
);

   // cnt never runs past TIMEOUT, so TIMEOUT fitting in CNT_W rules out wrap.
   if (TIMEOUT < 4 || longint'(TIMEOUT) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_timeout
      $error("div_period_meter: TIMEOUT must be in 4..2**CNT_W-1");
   end

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   logic rise;
   logic fall;

   sig_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (i_sig),
      .level    (),
      .rise     (rise),
      .fall     (fall)
   );

   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] hcnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         hcnt      <= '0;
         o_period  <= '0;
         o_high    <= '0;
         o_valid   <= 1'b0;
         o_timeout <= 1'b0;
         o_busy    <= 1'b0;
      end else begin
         o_valid   <= 1'b0;
         o_timeout <= 1'b0;
         case (state)
            IDLE: begin
               cnt  <= '0;
               hcnt <= '0;
               if (i_enable) begin
                  state  <= ARM;
                  o_busy <= 1'b1;
               end
            end
            ARM, MEASURE: begin
               if (!i_enable) begin
                  // Partial period is dropped; outputs keep their last values.
                  state  <= IDLE;
                  o_busy <= 1'b0;
                  cnt    <= '0;
                  hcnt   <= '0;
               end else if (rise) begin
                  // The rise cycle is cycle 1 of the next period, so no dead cycle
                  // between back-to-back measurements. A rise beats a timeout.
                  if (state == MEASURE) begin
                     o_period <= cnt;
                     o_high   <= hcnt;
                     o_valid  <= 1'b1;
                  end
                  state <= MEASURE;
                  cnt   <= ONE;
                  hcnt  <= '0;
               end else if (cnt == TIMEOUT_C) begin
                  o_timeout <= 1'b1;
                  o_period  <= '0;
                  o_high    <= '0;
                  state     <= ARM;
                  cnt       <= '0;
                  hcnt      <= '0;
               end else begin
                  cnt <= cnt + ONE;
                  // Falls while arming belong to no period and are ignored.
                  if (state == MEASURE && fall) begin
                     hcnt <= cnt;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               o_busy <= 1'b0;
               cnt    <= '0;
               hcnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_period_meter.sv
// tb/tb_div_period_meter.sv - directed self-checking bench for div_period_meter
module tb_div_period_meter;

   localparam int CNT_W = 28;

   logic             clk;
   logic             rst_n;
   logic             i_sig;
   logic             i_enable;
   logic [CNT_W-1:0] o_period;
   logic [CNT_W-1:0] o_high;
   logic             o_valid;
   logic             o_timeout;
   logic             o_busy;

   div_period_meter #(
      .CNT_W       (CNT_W),
      .TIMEOUT     (100),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_sig     (i_sig),
      .i_enable  (i_enable),
      .o_period  (o_period),
      .o_high    (o_high),
      .o_valid   (o_valid),
      .o_timeout (o_timeout),
      .o_busy    (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int valid_cnt   = 0;
   int first_valid = -1;
   int q_per[$];
   int q_high[$];
   int to_cycs[$];

   task automatic check(input string tag, input longint obs, input longint exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Drive i_sig for one clock, then sample outputs 1 time unit after the edge.
   // Every o_valid must match the oldest generated period still outstanding.
   task automatic cycle(input logic s);
      i_sig = s;
      @(posedge clk);
      #1;
      cyc++;
      if (o_valid) begin
         valid_cnt++;
         if (first_valid < 0) first_valid = cyc;
         if (q_per.size() == 0) begin
            check("unexpected_valid", o_valid, 0);
         end else begin
            check("period", o_period, q_per.pop_front());
            check("high", o_high, q_high.pop_front());
         end
      end
      if (o_timeout) to_cycs.push_back(cyc);
   endtask

   // One period: rise, h cycles high, p-h cycles low.
   task automatic wave(input int p, input int h);
      q_per.push_back(p);
      q_high.push_back(h);
      for (int i = 0; i < p; i++) cycle(i < h);
   endtask

   task automatic flush();
      q_per.delete();
      q_high.delete();
   endtask

   int snap;
   int rise_cyc;
   int busy_cyc;
   int t0;
   int t1;

   initial begin
      rst_n    = 1'b0;
      i_sig    = 1'b0;
      i_enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_period", o_period, 0);
      check("rst_high", o_high, 0);
      check("rst_valid", o_valid, 0);
      check("rst_timeout", o_timeout, 0);
      check("rst_busy", o_busy, 0);
      rst_n = 1'b1;
      repeat (3) cycle(0);
      check("idle_busy", o_busy, 0);

      // Steady 16/8, change to 10/3, then the 2/1 minimum, then back to 16/8.
      // The first rise only arms, so 19+3 periods give 21 strobes.
      i_enable = 1'b1;
      to_cycs.delete();
      repeat (6) cycle(0);
      check("arm_busy", o_busy, 1);
      repeat (5) wave(16, 8);
      repeat (6) wave(10, 3);
      repeat (8) wave(2, 1);
      repeat (3) wave(16, 8);
      check("stream_valid_count", valid_cnt, 21);
      check("stream_no_timeout", to_cycs.size(), 0);

      // Rise, then drop enable in the cycle where cnt==7 (rise seen 2 edges
      // after it is driven, cnt=1 one edge later). The closing strobe of the
      // last 16/8 period still arrives first.
      for (int i = 0; i < 9; i++) cycle(1);
      i_enable = 1'b0;
      cycle(1);
      check("drop_busy", o_busy, 0);
      check("drop_period", o_period, 16);
      check("drop_high", o_high, 8);
      snap = valid_cnt;
      flush();
      for (int i = 0; i < 32; i++) cycle((i % 16) < 8);
      check("drop_no_valid", valid_cnt, snap);
      check("drop_no_timeout", to_cycs.size(), 0);
      check("drop_period_held", o_period, 16);

      // Re-enable: rise driven at call r arms; the 12/5 strobe lands at r+12+2.
      i_enable = 1'b1;
      first_valid = -1;
      repeat (4) cycle(0);
      rise_cyc = cyc + 1;
      repeat (3) wave(12, 5);
      check("reenable_first_valid_delay", first_valid - rise_cyc, 14);
      check("reenable_valid_count", valid_cnt, snap + 2);

      // Timeout=100 with i_sig low: decision when cnt reaches 100, i.e. 100
      // cycles into ARM, registered pulse one cycle later; ARM restarts at 0
      // so pulses repeat every 101 cycles.
      i_enable = 1'b0;
      repeat (2) cycle(0);
      flush();
      to_cycs.delete();
      snap = valid_cnt;
      i_enable = 1'b1;
      cycle(0);
      check("to_busy", o_busy, 1);
      busy_cyc = cyc;
      repeat (215) cycle(0);
      check("to_pulse_count", to_cycs.size(), 2);
      t0 = (to_cycs.size() > 0) ? to_cycs[0] : -1000;
      t1 = (to_cycs.size() > 1) ? to_cycs[1] : -1000;
      check("to_first_delay", t0 - busy_cyc, 101);
      check("to_repeat", t1 - t0, 101);
      check("to_period", o_period, 0);
      check("to_high", o_high, 0);
      check("to_no_valid", valid_cnt, snap);

      // Async reset mid-period, checked before the next clock edge.
      flush();
      repeat (3) wave(16, 8);
      check("pre_rst_period", o_period, 16);
      repeat (5) cycle(1);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_period", o_period, 0);
      check("arst_high", o_high, 0);
      check("arst_valid", o_valid, 0);
      check("arst_timeout", o_timeout, 0);
      check("arst_busy", o_busy, 0);
      repeat (2) cycle(0);
      rst_n = 1'b1;
      flush();
      check("post_rst_busy", o_busy, 0);
      snap = valid_cnt;
      repeat (5) cycle(0);
      check("post_rst_arm", o_busy, 1);
      repeat (3) wave(16, 8);
      check("post_rst_valid_count", valid_cnt, snap + 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
